// File: rtl/rdagent_port.sv
// rtl/rdagent_port.sv - read-agent front end: accounter lookup, single-bank read, ordered response FIFO
module rdagent_port #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int NB_WRAGENT   = 2,
  parameter int SELECT_WIDTH = (NB_WRAGENT == 1) ? 1 : $clog2(NB_WRAGENT),
  parameter int FIFO_DEPTH   = 3
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  output logic                             acc_rden,
  output logic [ADDR_WIDTH-1:0]            acc_rdaddr,
  input  logic [SELECT_WIDTH-1:0]          acc_rdselect,
  output logic [NB_WRAGENT-1:0]            bank_rden,
  output logic [ADDR_WIDTH-1:0]            bank_rdaddr,
  input  logic [NB_WRAGENT*DATA_WIDTH-1:0] bank_rddata,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_data
);

  localparam int PTR_WIDTH = (FIFO_DEPTH <= 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_WIDTH-1:0] PTR_LAST  = PTR_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [CNT_WIDTH:0]   DEPTH_EXT = (CNT_WIDTH + 1)'(FIFO_DEPTH);

  logic                    accept;
  logic                    push;
  logic                    pop;
  logic                    inflight;
  logic                    sel_in_range;
  logic [SELECT_WIDTH-1:0] eff_sel;
  logic [SELECT_WIDTH-1:0] sel_q;
  logic [PTR_WIDTH-1:0]    wr_ptr;
  logic [PTR_WIDTH-1:0]    rd_ptr;
  logic [CNT_WIDTH-1:0]    count;
  logic [CNT_WIDTH:0]      occupancy;
  logic [DATA_WIDTH-1:0]   cap_data;
  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  // Slots already promised (buffered plus the read still in the RAM pipeline)
  // gate new requests, so a push can never land on a full FIFO.
  assign occupancy = {1'b0, count} + {{CNT_WIDTH{1'b0}}, inflight};
  assign req_ready = aresetn && (occupancy < DEPTH_EXT);
  assign accept    = req_valid && req_ready;
  assign acc_rden  = accept;

  assign acc_rdaddr  = req_addr;
  assign bank_rdaddr = req_addr;

  assign push      = inflight;
  assign rsp_valid = aresetn && (count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = mem[rd_ptr];

  // Fold a select that names a nonexistent bank onto bank 0.
  always_comb begin
    sel_in_range = 1'b0;
    for (int b = 0; b < NB_WRAGENT; b++) begin
      if (acc_rdselect == SELECT_WIDTH'(b)) sel_in_range = 1'b1;
    end
    eff_sel = sel_in_range ? acc_rdselect : '0;
  end

  // One-hot read enable towards the owning bank, only on an accepted request.
  always_comb begin
    bank_rden = '0;
    for (int b = 0; b < NB_WRAGENT; b++) begin
      bank_rden[b] = accept && (eff_sel == SELECT_WIDTH'(b));
    end
  end

  // Pick the returning bank's word using the select carried across the RAM latency.
  always_comb begin
    cap_data = bank_rddata[DATA_WIDTH-1:0];
    for (int b = 0; b < NB_WRAGENT; b++) begin
      if (sel_q == SELECT_WIDTH'(b)) cap_data = bank_rddata[DATA_WIDTH*b +: DATA_WIDTH];
    end
  end

  // Track the outstanding read and its bank select.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      inflight <= 1'b0;
      sel_q    <= '0;
    end else begin
      inflight <= accept;
      if (accept) sel_q <= eff_sel;
    end
  end

  // FIFO pointers and occupancy; push and pop in one cycle leave count alone.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are meaningless until count says otherwise, so no reset.
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= cap_data;
  end

endmodule

// File: tb/tb_rdagent_port.sv
// tb/tb_rdagent_port.sv - table-driven bench for rdagent_port
module tb_rdagent_port;

  logic        aclk;
  logic        aresetn;

  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_addr;
  logic        acc_rden;
  logic [7:0]  acc_rdaddr;
  logic        acc_rdselect;
  logic [1:0]  bank_rden;
  logic [7:0]  bank_rdaddr;
  logic [63:0] bank_rddata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;

  logic        req_valid3;
  logic        req_ready3;
  logic [7:0]  req_addr3;
  logic        acc_rden3;
  logic [7:0]  acc_rdaddr3;
  logic [1:0]  acc_rdselect3;
  logic [2:0]  bank_rden3;
  logic [7:0]  bank_rdaddr3;
  logic [95:0] bank_rddata3;
  logic        rsp_valid3;
  logic        rsp_ready3;
  logic [31:0] rsp_data3;

  int n_vec = 0;
  int n_err = 0;

  rdagent_port #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NB_WRAGENT(2), .FIFO_DEPTH(3)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .acc_rden(acc_rden), .acc_rdaddr(acc_rdaddr), .acc_rdselect(acc_rdselect),
    .bank_rden(bank_rden), .bank_rdaddr(bank_rdaddr), .bank_rddata(bank_rddata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
  );

  rdagent_port #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NB_WRAGENT(3), .FIFO_DEPTH(3)) dut3 (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_addr(req_addr3),
    .acc_rden(acc_rden3), .acc_rdaddr(acc_rdaddr3), .acc_rdselect(acc_rdselect3),
    .bank_rden(bank_rden3), .bank_rdaddr(bank_rdaddr3), .bank_rddata(bank_rddata3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic owner(input logic [7:0] a);
    return a[0] ^ a[4];
  endfunction

  function automatic logic [31:0] data_of(input int b, input logic [7:0] a);
    if (b == 1 && a == 8'h12) return 32'hCAFE0001;
    return {8'(b), 16'h00A5, a};
  endfunction

  function automatic logic [31:0] exp_rsp(input logic [7:0] a);
    return data_of(int'(owner(a)), a);
  endfunction

  // Accounter model: row ownership is a fixed function of the address.
  assign acc_rdselect = owner(acc_rdaddr);

  // Two-bank RAM model with one cycle of read latency; idle banks return junk.
  always @(posedge aclk) begin
    for (int b = 0; b < 2; b++) begin
      if (bank_rden[b]) bank_rddata[32*b +: 32] <= data_of(b, bank_rdaddr);
      else              bank_rddata[32*b +: 32] <= 32'hDEAD0000 | 32'(b);
    end
  end

  // Three-bank RAM model for the out-of-range select instance.
  always @(posedge aclk) begin
    for (int b = 0; b < 3; b++) begin
      if (bank_rden3[b]) bank_rddata3[32*b +: 32] <= data_of(b, bank_rdaddr3);
      else               bank_rddata3[32*b +: 32] <= 32'hBEEF0000 | 32'(b);
    end
  end

  typedef struct {
    logic        rstn;
    logic        valid;
    logic [7:0]  addr;
    logic        rsp_rdy;
    logic        e_ready;
    logic [1:0]  e_rden;
    logic        e_rvalid;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rstn, input logic valid, input logic [7:0] addr,
                              input logic rsp_rdy, input logic e_ready, input logic e_rvalid,
                              input logic [31:0] e_data);
    vec_t v;
    v.rstn     = rstn;
    v.valid    = valid;
    v.addr     = addr;
    v.rsp_rdy  = rsp_rdy;
    v.e_ready  = e_ready;
    v.e_rden   = (valid && e_ready) ? (owner(addr) ? 2'b10 : 2'b01) : 2'b00;
    v.e_rvalid = e_rvalid;
    v.e_data   = e_data;
    tbl.push_back(v);
  endfunction

  function automatic void add_stream(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      add(1, 1, base + 8'(i), 1, 1, i >= 2, (i >= 2) ? exp_rsp(base + 8'(i - 2)) : 32'h0);
    end
    add(1, 0, 8'h00, 1, 1, 1, exp_rsp(base + 8'(n - 2)));
    add(1, 0, 8'h00, 1, 1, 1, exp_rsp(base + 8'(n - 1)));
    add(1, 0, 8'h00, 1, 1, 0, 32'h0);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    aresetn       = 1'b0;
    req_valid     = 1'b0;
    req_addr      = 8'h00;
    rsp_ready     = 1'b0;
    req_valid3    = 1'b0;
    req_addr3     = 8'h00;
    acc_rdselect3 = 2'd0;
    rsp_ready3    = 1'b1;

    // Reset: an offered request must not be taken
    add(0, 1, 8'h12, 0, 0, 0, 32'h0);
    add(0, 1, 8'h12, 0, 0, 0, 32'h0);
    // Single read to bank 1, response at T+2, gone at T+3
    add(1, 1, 8'h12, 1, 1, 0, 32'h0);
    add(1, 0, 8'h00, 1, 1, 0, 32'h0);
    add(1, 0, 8'h00, 1, 1, 1, 32'hCAFE0001);
    add(1, 0, 8'h00, 1, 1, 0, 32'h0);
    // Back-to-back, selects alternating 0/1
    add_stream(8'h20, 8);
    // Backpressure: three accepts, stall, drain, req_ready back the cycle after first pop
    add(1, 1, 8'h40, 0, 1, 0, 32'h0);
    add(1, 1, 8'h41, 0, 1, 0, 32'h0);
    add(1, 1, 8'h42, 0, 1, 1, exp_rsp(8'h40));
    add(1, 1, 8'h43, 0, 0, 1, exp_rsp(8'h40));
    add(1, 1, 8'h43, 0, 0, 1, exp_rsp(8'h40));
    add(1, 1, 8'h43, 1, 0, 1, exp_rsp(8'h40));
    add(1, 1, 8'h43, 1, 1, 1, exp_rsp(8'h41));
    add(1, 0, 8'h00, 1, 1, 1, exp_rsp(8'h42));
    add(1, 0, 8'h00, 1, 1, 1, exp_rsp(8'h43));
    add(1, 0, 8'h00, 1, 1, 0, 32'h0);
    // Sustained push+pop with count held at 1 across several pointer wraps
    add_stream(8'h60, 12);
    // Mid-operation reset with two buffered and one in flight
    add(1, 1, 8'h80, 0, 1, 0, 32'h0);
    add(1, 1, 8'h81, 0, 1, 0, 32'h0);
    add(1, 1, 8'h82, 0, 1, 1, exp_rsp(8'h80));
    add(0, 1, 8'h83, 1, 0, 0, 32'h0);
    add(1, 1, 8'h85, 1, 1, 0, 32'h0);
    add(1, 0, 8'h00, 1, 1, 0, 32'h0);
    add(1, 0, 8'h00, 1, 1, 1, exp_rsp(8'h85));
    add(1, 0, 8'h00, 1, 1, 0, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge aclk);
      aresetn   = tbl[i].rstn;
      req_valid = tbl[i].valid;
      req_addr  = tbl[i].addr;
      rsp_ready = tbl[i].rsp_rdy;
      #1;
      chk("req_ready", i, 32'(req_ready), 32'(tbl[i].e_ready));
      chk("bank_rden", i, 32'(bank_rden), 32'(tbl[i].e_rden));
      chk("acc_rden", i, 32'(acc_rden), 32'(|tbl[i].e_rden));
      chk("bank_rdaddr", i, 32'(bank_rdaddr), 32'(tbl[i].addr));
      chk("rsp_valid", i, 32'(rsp_valid), 32'(tbl[i].e_rvalid));
      if (tbl[i].e_rvalid) chk("rsp_data", i, rsp_data, tbl[i].e_data);
    end

    // Three-bank instance: select 3 does not exist and must fall back to bank 0
    @(negedge aclk);
    req_valid3 = 1'b1; req_addr3 = 8'h33; acc_rdselect3 = 2'd3;
    #1;
    chk("oor_rden", 0, 32'(bank_rden3), 32'(3'b001));
    chk("oor_acc_rden", 0, 32'(acc_rden3), 32'h1);
    @(negedge aclk);
    req_valid3 = 1'b1; req_addr3 = 8'h34; acc_rdselect3 = 2'd2;
    #1;
    chk("oor_rden", 1, 32'(bank_rden3), 32'(3'b100));
    @(negedge aclk);
    req_valid3 = 1'b0; req_addr3 = 8'h00; acc_rdselect3 = 2'd0;
    #1;
    chk("oor_rsp_valid", 2, 32'(rsp_valid3), 32'h1);
    chk("oor_rsp_data", 2, rsp_data3, data_of(0, 8'h33));
    @(negedge aclk);
    #1;
    chk("oor_rsp_valid", 3, 32'(rsp_valid3), 32'h1);
    chk("oor_rsp_data", 3, rsp_data3, data_of(2, 8'h34));
    @(negedge aclk);
    #1;
    chk("oor_rsp_valid", 4, 32'(rsp_valid3), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
